// File: rtl/operators1_pkg.sv
// -----------------------------------------------------------------------------
// operators1_pkg
//   Shared types and defaults for the parameterised channel multiplexer /
//   arbiter (mux_arb_param) and its grant sub-module (rr_arbiter).
//
//   mux_mode_t        : arbitration mode, MUX_SEL (direct select) or MUX_RR
//                       (round-robin search starting at the stored pointer).
//   MUX_DEF_WIDTH     : default data width per channel.
//   MUX_DEF_CHANNELS  : default number of input channels.
// -----------------------------------------------------------------------------
package operators1_pkg;

    typedef enum logic {
        MUX_SEL = 1'b0,
        MUX_RR  = 1'b1
    } mux_mode_t;

    localparam int MUX_DEF_WIDTH    = 8;
    localparam int MUX_DEF_CHANNELS = 4;

endpackage

// File: rtl/mux_arb_param_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational grant search. Looks at i_ptr, i_ptr+1, ... wrapping
//   modulo CHANNELS and grants the first requesting channel.
//
//   Ports
//     i_req    [CHANNELS]  request vector
//     i_ptr    [SEL_W]     first index to examine (must be < CHANNELS)
//     o_grant  [CHANNELS]  one-hot grant, zero when nothing requests
//     o_idx    [SEL_W]     index of granted channel (0 when o_found is low)
//     o_found              a grant was made
// -----------------------------------------------------------------------------
module rr_arbiter
    import operators1_pkg::*;
#(
    parameter int CHANNELS = MUX_DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic [CHANNELS-1:0] o_grant,
    output logic [SEL_W-1:0]    o_idx,
    output logic                o_found
);

    // Rotated search: candidate c walks from the pointer upward and wraps
    // with a single subtraction, which is enough because i_ptr < CHANNELS.
    always_comb begin
        int c;
        c       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            c = int'(i_ptr) + k;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            if (!o_found && i_req[c]) begin
                o_found    = 1'b1;
                o_idx      = SEL_W'(c);
                o_grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_param.sv
// -----------------------------------------------------------------------------
// mux_arb_param
//   Selects one of CHANNELS valid/ready input streams into a single registered
//   output beat. In MUX_SEL the channel is chosen by sel; in MUX_RR a rotating
//   pointer gives round-robin fairness. One output register, one-cycle latency,
//   full throughput while out_ready stays high.
//
//   Ports
//     clk        single clock, rising edge
//     rst_n      asynchronous active-low reset
//     mode       mux_mode_t arbitration mode
//     sel        channel index used in MUX_SEL
//     in_data    CHANNELS x WIDTH channel data
//     in_valid   per-channel valid
//     in_ready   per-channel accept (one-hot or zero)
//     out_data   registered selected data
//     out_ch     index of the channel that supplied out_data
//     out_valid  out_data / out_ch hold a beat
//     out_ready  downstream accepts the held beat
// -----------------------------------------------------------------------------
module mux_arb_param
    import operators1_pkg::*;
#(
    parameter int WIDTH    = MUX_DEF_WIDTH,
    parameter int CHANNELS = MUX_DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  mux_mode_t           mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic [WIDTH-1:0]    in_data [CHANNELS],
    input  logic [CHANNELS-1:0] in_valid,
    output logic [CHANNELS-1:0] in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    if (CHANNELS < 2 || CHANNELS > 16) begin : g_bad_channels
        $error("mux_arb_param: CHANNELS must be in 2..16");
    end

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_acc;
    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_grant;
    logic [SEL_W-1:0]    w_idx;
    logic                w_found;
    logic [SEL_W-1:0]    w_ptr_next;

    // The output register can take a new beat when empty or being drained.
    assign w_acc = !r_out_valid || out_ready;

    // In MUX_SEL only the selected channel may request, so the shared
    // rotating search degenerates to "is sel valid". An out-of-range sel
    // matches no channel and therefore yields no grant.
    always_comb begin
        w_req = '0;
        if (mode == MUX_RR) begin
            w_req = in_valid;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel) == i) begin
                    w_req[i] = in_valid[i];
                end
            end
        end
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    // Gated by rst_n so that no accept leaks out while reset is held, even
    // though the emptied output register would otherwise look acceptable.
    assign in_ready = (rst_n && w_acc) ? w_grant : '0;

    assign w_ptr_next = (int'(w_idx) == CHANNELS - 1) ? '0 : w_idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else begin
            if (w_acc) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_data <= in_data[w_idx];
                    r_out_ch   <= w_idx;
                end
            end
            // Only an accepted round-robin grant advances fairness state;
            // direct selections leave the rotation where it was.
            if (w_acc && w_found && mode == MUX_RR) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
